// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity sequence generator/checker.
// The parity helper takes zero-extended data; WIDTH must not exceed PAR_MAX_W.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned PAR_MAX_W = 64;

    // Zero padding leaves the XOR reduction unchanged.
    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_checker.sv
// Parity checker: counts received beats whose parity bit disagrees with the data,
// with a saturating counter and a sticky flag, both cleared by clr_err.
module parity_checker
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chk_valid,
    input  logic [WIDTH-1:0]     chk_data,
    input  logic                 chk_par,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    localparam logic                 OddBit = (ODD_PARITY != 0);
    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    logic [PAR_MAX_W-1:0] data_ext;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic                 err_sticky_d, err_sticky_q;

    // Clear is applied before the increment so a simultaneous error still counts once.
    always_comb begin
        data_ext               = '0;
        data_ext[WIDTH-1:0]    = chk_data;
        err                    = chk_valid && (chk_par != parity_of(data_ext, OddBit));
        err_cnt_d              = clr_err ? '0 : err_cnt_q;
        err_sticky_d           = clr_err ? 1'b0 : err_sticky_q;
        if (err) begin
            if (err_cnt_d != CntMax) begin
                err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: rtl/parity_seq_gen_chk.sv
// Round-robin multi-channel incrementing-data generator with per-beat parity,
// plus an independent parity checker for the returned stream.
module parity_seq_gen_chk
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned STEP       = 1,
    parameter int unsigned ERR_CNT_W  = 8,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     seed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_par,
    output logic [CH_W-1:0]      out_ch,
    output logic                 busy,
    input  logic                 chk_valid,
    input  logic [WIDTH-1:0]     chk_data,
    input  logic                 chk_par,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    localparam logic             OddBit = (ODD_PARITY != 0);
    localparam logic [WIDTH-1:0] StepW  = WIDTH'(STEP);
    localparam logic [CH_W-1:0]  LastCh = CH_W'(NUM_CH - 1);

    state_e               state_d, state_q;
    logic [WIDTH-1:0]     cnt_d [NUM_CH];
    logic [WIDTH-1:0]     cnt_q [NUM_CH];
    logic [CH_W-1:0]      ch_ptr_d, ch_ptr_q;
    logic                 out_valid_d, out_valid_q;
    logic [WIDTH-1:0]     out_data_d, out_data_q;
    logic                 out_par_d, out_par_q;
    logic [CH_W-1:0]      out_ch_d, out_ch_q;
    logic                 busy_d, busy_q;

    logic                 hs;
    logic [CH_W-1:0]      ptr_nxt;
    logic                 load_beat;
    logic [WIDTH-1:0]     beat_data;
    logic [CH_W-1:0]      beat_ch;
    logic [PAR_MAX_W-1:0] beat_ext;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_ptr_d    = ch_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_ch_d    = out_ch_q;
        busy_d      = busy_q;
        load_beat   = 1'b0;
        beat_data   = out_data_q;
        beat_ch     = out_ch_q;
        beat_ext    = '0;

        hs      = out_valid_q && out_ready;
        ptr_nxt = (ch_ptr_q == LastCh) ? '0 : ch_ptr_q + CH_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        cnt_d[c] = seed + WIDTH'(c);
                    end
                    ch_ptr_d  = '0;
                    load_beat = 1'b1;
                    beat_data = seed;
                    beat_ch   = '0;
                    state_d   = RUN;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    cnt_d[ch_ptr_q] = cnt_q[ch_ptr_q] + StepW;
                    ch_ptr_d        = ptr_nxt;
                    if (stop) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        // With one channel ptr_nxt == ch_ptr_q, so this picks the just-updated count.
                        load_beat = 1'b1;
                        beat_data = cnt_d[ptr_nxt];
                        beat_ch   = ptr_nxt;
                    end
                end else if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    cnt_d[ch_ptr_q] = cnt_q[ch_ptr_q] + StepW;
                    ch_ptr_d        = ptr_nxt;
                    state_d         = IDLE;
                    out_valid_d     = 1'b0;
                    busy_d          = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        if (load_beat) begin
            beat_ext[WIDTH-1:0] = beat_data;
            out_valid_d         = 1'b1;
            out_data_d          = beat_data;
            out_par_d           = parity_of(beat_ext, OddBit);
            out_ch_d            = beat_ch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
            ch_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= OddBit;
            out_ch_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_ptr_q    <= ch_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_ch_q    <= out_ch_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_ch    = out_ch_q;
    assign busy      = busy_q;

    parity_checker #(
        .WIDTH      (WIDTH),
        .ODD_PARITY (ODD_PARITY),
        .ERR_CNT_W  (ERR_CNT_W)
    ) u_checker (
        .clk        (clk),
        .reset_n    (reset_n),
        .chk_valid  (chk_valid),
        .chk_data   (chk_data),
        .chk_par    (chk_par),
        .clr_err    (clr_err),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

endmodule
